// File: rtl/debounce_event.sv
// Multi-channel synchroniser + debouncer producing debounced levels, one-cycle
// rise/fall pulses and a long-press held flag; all lanes share one sample prescaler.

module debounce_lane #(
  parameter int   N           = 3,
  parameter int   SYNC_STAGES = 2,
  parameter int   HOLD_TICKS  = 0,
  parameter int   HW          = 1,
  parameter logic INIT        = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic din,
  output logic out,
  output logic rise,
  output logic fall,
  output logic held,
  output logic evt
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [N-1:0]           hist, hist_nxt;
  logic                   go_hi, go_lo;

  generate
    if (N == 1) begin : g_h1
      assign hist_nxt = sync_q[SYNC_STAGES-1];
    end else begin : g_hn
      assign hist_nxt = {hist[N-2:0], sync_q[SYNC_STAGES-1]};
    end
  endgenerate

  // Decision looks at the registered history, so a full N-sample window is needed.
  assign go_hi = tick & (&hist) & ~out;
  assign go_lo = tick & ~(|hist) & out;
  assign evt   = go_hi | go_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{INIT}};
      hist   <= {N{INIT}};
      out    <= INIT;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      if (tick) hist <= hist_nxt;
      rise <= go_hi;
      fall <= go_lo;
      if (go_hi)      out <= 1'b1;
      else if (go_lo) out <= 1'b0;
    end
  end

  generate
    if (HOLD_TICKS > 0) begin : g_hold
      localparam logic [HW-1:0] HMAX = HW'(HOLD_TICKS);
      logic [HW-1:0] hcnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          hcnt <= '0;
          held <= 1'b0;
        end else if (go_lo) begin
          hcnt <= '0;
          held <= 1'b0;
        end else if (tick && out && hcnt != HMAX) begin
          hcnt <= hcnt + HW'(1);
          held <= (hcnt + HW'(1)) == HMAX;
        end
      end
    end else begin : g_nohold
      assign held = 1'b0;
    end
  endgenerate
endmodule

module debounce_event #(
  parameter int               WIDTH       = 8,
  parameter int               N           = 3,
  parameter int               RATE        = 125000,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] INIT        = '0,
  parameter int               HOLD_TICKS  = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] held,
  output logic             changed
);
  localparam int CW = (RATE > 1) ? $clog2(RATE) : 1;
  localparam int HW = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  logic             tick;
  logic [WIDTH-1:0] evt;

  generate
    if (RATE > 1) begin : g_presc
      localparam logic [CW-1:0] LAST = CW'(RATE - 1);
      logic [CW-1:0] cnt;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)           cnt <= '0;
        else if (cnt == LAST) cnt <= '0;
        else                  cnt <= cnt + CW'(1);
      end
      assign tick = (cnt == LAST);
    end else begin : g_every
      assign tick = 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      debounce_lane #(
        .N(N), .SYNC_STAGES(SYNC_STAGES), .HOLD_TICKS(HOLD_TICKS),
        .HW(HW), .INIT(INIT[i])
      ) u_lane (
        .clk(clk), .rst_n(rst_n), .tick(tick), .din(in[i]),
        .out(out[i]), .rise(rise[i]), .fall(fall[i]), .held(held[i]), .evt(evt[i])
      );
    end
  endgenerate

  // Built from next-state terms so it lands on the same edge as rise/fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) changed <= 1'b0;
    else        changed <= |evt;
  end
endmodule

// File: tb/tb_debounce_event.sv
// Bench for debounce_event: two configurations checked every cycle against a
// window-based reference model of the raw input history, plus directed cases.

module tb_debounce_event;
  localparam int NS = 3;
  localparam int SS = 2;
  localparam int RA = 1;
  localparam int RB = 4;
  localparam int HA = 5;
  localparam int HB = 3;
  localparam logic [7:0] IA = 8'h0F;
  localparam logic [7:0] IB = 8'h00;

  logic clk = 1'b0;
  logic rst_n;
  logic [7:0] in_a, in_b;
  logic [7:0] out_a, rise_a, fall_a, held_a;
  logic [7:0] out_b, rise_b, fall_b, held_b;
  logic       chg_a, chg_b;

  always #5 clk = ~clk;

  debounce_event #(.WIDTH(8), .N(NS), .RATE(RA), .SYNC_STAGES(SS), .INIT(IA), .HOLD_TICKS(HA)) dut_a (
    .clk(clk), .rst_n(rst_n), .in(in_a), .out(out_a), .rise(rise_a),
    .fall(fall_a), .held(held_a), .changed(chg_a));

  debounce_event #(.WIDTH(8), .N(NS), .RATE(RB), .SYNC_STAGES(SS), .INIT(IB), .HOLD_TICKS(HB)) dut_b (
    .clk(clk), .rst_n(rst_n), .in(in_b), .out(out_b), .rise(rise_b),
    .fall(fall_b), .held(held_b), .changed(chg_b));

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model: raw input seen before each edge since reset release.
  logic [7:0] hist [2][4096];
  int         k;
  logic [7:0] m_out [2];
  logic [7:0] m_rise [2];
  logic [7:0] m_fall [2];
  logic [7:0] m_held [2];
  logic       m_chg [2];
  int         m_hc [2][8];

  function automatic logic [7:0] initv(int d);
    return (d == 0) ? IA : IB;
  endfunction
  function automatic int rate_of(int d);
    return (d == 0) ? RA : RB;
  endfunction
  function automatic int hold_of(int d);
    return (d == 0) ? HA : HB;
  endfunction
  function automatic logic in_at(int d, int idx, int ch);
    logic [7:0] v;
    if (idx < 1) v = initv(d);
    else         v = hist[d][idx];
    return v[ch];
  endfunction

  task automatic model_reset();
    k = 0;
    for (int d = 0; d < 2; d++) begin
      m_out[d] = initv(d); m_rise[d] = '0; m_fall[d] = '0; m_held[d] = '0; m_chg[d] = 1'b0;
      for (int c = 0; c < 8; c++) m_hc[d][c] = 0;
    end
  endtask

  // Sample edges are every RATE-th edge; the level changes once the N samples
  // taken at the preceding sample edges (input delayed by the sync chain) agree.
  task automatic model_edge();
    k++;
    hist[0][k] = in_a;
    hist[1][k] = in_b;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < 8; c++) begin
        logic rs, fs, a1, a0;
        rs = 1'b0; fs = 1'b0;
        if (k % rate_of(d) == 0) begin
          a1 = 1'b1; a0 = 1'b1;
          for (int j = 1; j <= NS; j++) begin
            if (in_at(d, k - j * rate_of(d) - SS, c)) a0 = 1'b0;
            else                                      a1 = 1'b0;
          end
          if (a0 && m_out[d][c]) begin
            fs = 1'b1; m_out[d][c] = 1'b0; m_hc[d][c] = 0;
          end else begin
            if (m_out[d][c] && m_hc[d][c] < hold_of(d)) m_hc[d][c]++;
            if (a1 && !m_out[d][c]) begin rs = 1'b1; m_out[d][c] = 1'b1; end
          end
        end
        m_rise[d][c] = rs;
        m_fall[d][c] = fs;
        m_held[d][c] = (hold_of(d) > 0) && (m_hc[d][c] == hold_of(d));
      end
      m_chg[d] = |(m_rise[d] | m_fall[d]);
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cmp_all(string tag);
    chk({tag, "/out_a"},  32'(out_a),  32'(m_out[0]));
    chk({tag, "/rise_a"}, 32'(rise_a), 32'(m_rise[0]));
    chk({tag, "/fall_a"}, 32'(fall_a), 32'(m_fall[0]));
    chk({tag, "/held_a"}, 32'(held_a), 32'(m_held[0]));
    chk({tag, "/chg_a"},  32'(chg_a),  32'(m_chg[0]));
    chk({tag, "/out_b"},  32'(out_b),  32'(m_out[1]));
    chk({tag, "/rise_b"}, 32'(rise_b), 32'(m_rise[1]));
    chk({tag, "/fall_b"}, 32'(fall_b), 32'(m_fall[1]));
    chk({tag, "/held_b"}, 32'(held_b), 32'(m_held[1]));
    chk({tag, "/chg_b"},  32'(chg_b),  32'(m_chg[1]));
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
    cmp_all(tag);
  endtask

  initial begin
    int r_at, h_at, c0, lat;
    logic prev_held, seen;

    // Reset with inputs at INIT: levels follow INIT, nothing pulses.
    in_a = IA; in_b = IB; rst_n = 1'b0;
    model_reset();
    #12;
    cmp_all("reset");
    @(negedge clk) rst_n = 1'b1;
    repeat (20) step("idle");

    // Single-cycle-rate latency on a channel whose INIT is 0.
    in_a[4] = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step("lat");
      chk($sformatf("lat_rise_e%0d", e), 32'(rise_a[4]), 32'(e == 6));
      if (e == 6) chk("lat_out_e6", 32'(out_a[4]), 32'd1);
    end

    // Two-cycle glitch must be rejected.
    in_a[5] = 1'b1;
    step("glitch"); step("glitch");
    in_a[5] = 1'b0;
    repeat (20) step("glitch");
    chk("glitch_out", 32'(out_a[5]), 32'd0);

    // Prescaled channel: rise lands N ticks after the synced edge, plus phase.
    in_b[2] = 1'b1;
    c0 = cyc; seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      step("presc");
      if (out_b[2]) seen = 1'b1;
    end
    chk("presc_seen", 32'(seen), 32'd1);
    lat = cyc - (c0 + SS);
    chk("presc_window", 32'(lat >= NS * RB && lat <= NS * RB + RB), 32'd1);

    // Long press: held sets HOLD_TICKS cycles after rise, clears with fall.
    in_a[6] = 1'b1;
    r_at = -1; h_at = -1;
    for (int t = 0; t < 30 && h_at < 0; t++) begin
      step("hold");
      if (rise_a[6]) r_at = cyc;
      if (held_a[6] && h_at < 0) h_at = cyc;
    end
    chk("hold_delay", 32'(h_at - r_at), 32'(HA));
    in_a[6] = 1'b0;
    seen = 1'b0; prev_held = held_a[6];
    for (int t = 0; t < 30 && !seen; t++) begin
      prev_held = held_a[6];
      step("release");
      if (fall_a[6]) seen = 1'b1;
    end
    chk("release_fall", 32'(seen), 32'd1);
    chk("release_held_prev", 32'(prev_held), 32'd1);
    chk("release_held_now", 32'(held_a[6]), 32'd0);

    // Reset mid-filter: outputs drop asynchronously, partial history discarded.
    in_a[7] = 1'b1;
    repeat (4) step("mid");
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out_a", 32'(out_a), 32'(IA));
    chk("async_held_a", 32'(held_a), 32'd0);
    chk("async_rise_a", 32'(rise_a), 32'd0);
    chk("async_out_b", 32'(out_b), 32'(IB));
    cmp_all("async");
    repeat (2) @(posedge clk);
    #1 cmp_all("in_reset");
    @(negedge clk) rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      step("refill");
      chk($sformatf("refill_rise_e%0d", e), 32'(rise_a[7]), 32'(e == 6));
    end

    // Randomised traffic on both configurations.
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 3) == 0) in_a ^= 8'(1 << $urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) in_b ^= 8'(1 << $urandom_range(0, 7));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
